// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: round-robin green-phase scheduler for a four-approach
// intersection (N/S/E/W). Each phase runs GREEN -> YELLOW -> ALLRED on an
// 8-bit down-counter, and all outputs are registered.
// Optional feature macro: TLC_PED_EN adds a pedestrian all-red WALK phase.
// Without it, ped_btn is ignored and walk is tied low.
module tlc_phase_scheduler #(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ped_btn,
    output logic [2:0] n_lights,
    output logic [2:0] s_lights,
    output logic [2:0] e_lights,
    output logic [2:0] w_lights,
    output logic [1:0] active_dir,
    output logic       walk,
    output logic       busy
);

    localparam logic [7:0] GREEN_LD  = 8'(GREEN_CYC - 1);
    localparam logic [7:0] YELLOW_LD = 8'(YELLOW_CYC - 1);
    localparam logic [7:0] ALLRED_LD = 8'(ALLRED_CYC - 1);

`ifdef TLC_PED_EN
    localparam logic [7:0] WALK_LD = 8'(WALK_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GREEN, S_YELLOW, S_ALLRED, S_WALK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_GREEN, S_YELLOW, S_ALLRED
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // The round-robin pointer 'last' and active_dir are always equal (both are
    // loaded with the winner on every grant and reset to W), so one register
    // serves as both.
    logic [1:0]  dir_q, dir_d;

    logic [11:0] lamp_q, lamp_d;
    logic        busy_q, busy_d;
    logic        walk_q, walk_d;

    logic        expired;
    logic        any_req;
    logic        competing;
    logic [1:0]  pick;
    logic        ped_pend_w;

    // Round-robin search starting at last+1; walking from farthest to nearest
    // leaves the nearest requester in pick. The current holder (i=4 wraps to
    // last) is considered last, so it wins only as the sole requester.
    function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                           input logic [3:0] r);
        logic [1:0] p;
        logic [1:0] idx;
        p = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) begin
                p = idx;
            end
        end
        return p;
    endfunction

    assign expired   = (cnt_q == 8'd0);
    assign any_req   = |req;
    assign pick      = rr_pick(dir_q, req);
    assign competing = (|(req & ~(4'b0001 << dir_q))) | ped_pend_w;

`ifdef TLC_PED_EN
    logic ped_btn_q;
    logic ped_pend_q, ped_pend_d;
    logic enter_walk;

    assign ped_pend_w = ped_pend_q;
    // A new button edge wins over the clear on WALK entry.
    assign ped_pend_d = (ped_btn & ~ped_btn_q) | (ped_pend_q & ~enter_walk);
    assign enter_walk = (state_d == S_WALK) && (state_q != S_WALK);

    // Button edge detector and pending-walk flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_btn_q  <= 1'b0;
            ped_pend_q <= 1'b0;
        end else begin
            ped_btn_q  <= ped_btn;
            ped_pend_q <= ped_pend_d;
        end
    end
`else
    logic unused_ped_btn;
    assign ped_pend_w     = 1'b0;
    assign unused_ped_btn = ped_btn;
`endif

    // Next-state, counter and grant decisions for the phase sequencer.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = expired ? 8'd0 : cnt_q - 8'd1;
        case (state_q)
            S_IDLE: begin
`ifdef TLC_PED_EN
                if (ped_pend_q) begin
                    state_d = S_WALK;
                    cnt_d   = WALK_LD;
                end else
`endif
                if (any_req) begin
                    state_d = S_GREEN;
                    dir_d   = pick;
                    cnt_d   = GREEN_LD;
                end
            end
            S_GREEN: begin
                if (expired) begin
                    if (competing) begin
                        state_d = S_YELLOW;
                        cnt_d   = YELLOW_LD;
                    end else begin
                        cnt_d   = GREEN_LD;
                    end
                end
            end
            S_YELLOW: begin
                if (expired) begin
                    state_d = S_ALLRED;
                    cnt_d   = ALLRED_LD;
                end
            end
            S_ALLRED: begin
                if (expired) begin
`ifdef TLC_PED_EN
                    if (ped_pend_q) begin
                        state_d = S_WALK;
                        cnt_d   = WALK_LD;
                    end else
`endif
                    if (any_req) begin
                        state_d = S_GREEN;
                        dir_d   = pick;
                        cnt_d   = GREEN_LD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end
                end
            end
`ifdef TLC_PED_EN
            S_WALK: begin
                if (expired) begin
                    if (any_req) begin
                        state_d = S_GREEN;
                        dir_d   = pick;
                        cnt_d   = GREEN_LD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Lamp pattern per approach, derived from the next state so the lamps
    // update on the same edge as the state.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lamp
        assign lamp_d[3*gi +: 3] =
            (dir_d == 2'(gi) && state_d == S_GREEN)  ? 3'b001 :
            (dir_d == 2'(gi) && state_d == S_YELLOW) ? 3'b010 : 3'b100;
    end

    assign busy_d = (state_d != S_IDLE);
`ifdef TLC_PED_EN
    assign walk_d = (state_d == S_WALK);
`else
    assign walk_d = 1'b0;
`endif

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            dir_q   <= 2'd3;
            lamp_q  <= {4{3'b100}};
            busy_q  <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            lamp_q  <= lamp_d;
            busy_q  <= busy_d;
            walk_q  <= walk_d;
        end
    end

    assign n_lights   = lamp_q[2:0];
    assign s_lights   = lamp_q[5:3];
    assign e_lights   = lamp_q[8:6];
    assign w_lights   = lamp_q[11:9];
    assign active_dir = dir_q;
    assign busy       = busy_q;
    assign walk       = walk_q;

endmodule
